fft_sample_loader: RTL and testbench
====================================

# fft_sample_loader

Input stage of the FFT pipeline, sitting directly upstream of the `scramble` layer. It accepts a frame of `FFT_SIZE` complex samples over a valid/ready stream and sign-extends each part to half-word width. It packs the samples into `WORD_SIZE` complex words and writes them in pairs into the input region of the dual-port FFT RAM through its A/B write ports. When the frame is complete it emits a one-cycle `o_done`, so the layer-select logic can hand the bus to the scramble layer.

## Interface
- `WORD_SIZE`, 74: complex word width; real part in `[WORD_SIZE-1:WORD_SIZE/2]`, imaginary part in `[WORD_SIZE/2-1:0]`.
- `SAMPLE_SIZE`, 16: signed width of each input component; must be ≤ `WORD_SIZE/2`.
- `FFT_SIZE`, 8: samples per frame; power of two, ≥ 2.
- `ADDR_SIZE`, 4: RAM address width.
- `BASE_ADDR`, 0: RAM address of sample 0; the frame occupies `BASE_ADDR .. BASE_ADDR+FFT_SIZE-1`.

Ports:
- `i_CLK`  in  1  single clock; all state changes on rising edge.
- `i_RST`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  begin a frame; honoured only in IDLE.
- `i_valid`  in  1  input sample present.
- `i_sample_re`  in  `SAMPLE_SIZE`  signed real part.
- `i_sample_im`  in  `SAMPLE_SIZE`  signed imaginary part.
- `o_ready`  out  1  loader can accept a sample this cycle.
- `o_busy`  out  1  frame in progress (any state except IDLE).
- `o_wren`  out  1  RAM write enable, applies to both ports.
- `o_wraddr_A`  out  `ADDR_SIZE`  even-sample address.
- `o_wraddr_B`  out  `ADDR_SIZE`  odd-sample address.
- `o_wrdata_A`  out  `WORD_SIZE`  even-sample word.
- `o_wrdata_B`  out  `WORD_SIZE`  odd-sample word.
- `o_done`  out  1  one-cycle pulse after the last write.

## Operation
- States: IDLE → LOAD → FLUSH → DONE → IDLE.
- IDLE: `o_ready`=0. `i_start`=1 moves to LOAD with sample counter `n`=0.
- LOAD: `o_ready`=1. A sample is accepted on each edge where `i_valid && o_ready`.
  - Word format: `{sext(re), sext(im)}`, each part sign-extended to `WORD_SIZE/2` bits.
  - Even `n`: the word goes to the hold register.
  - Odd `n`: next cycle `o_wren`=1, `o_wrdata_A`=hold, `o_wrdata_B`=current word, `o_wraddr_A`=`BASE_ADDR+n-1`, `o_wraddr_B`=`BASE_ADDR+n`.
  - `n` increments on every accept.
- Acceptance of sample `n=FFT_SIZE-1` moves to FLUSH. FLUSH issues the final pair write with `o_ready`=0.
- DONE: `o_done`=1 for exactly one cycle, `o_ready`=0, then IDLE.
- Address arithmetic is modulo 2^`ADDR_SIZE`.
- `i_start` outside IDLE is ignored. `i_valid` in IDLE/FLUSH/DONE is ignored; no sample is consumed.
- `i_start` and `i_valid` in the same IDLE cycle: only the start is taken; the sample is not accepted.
- Gaps in `i_valid` stall the frame indefinitely; there is no timeout.
- Reset asserted mid-frame: the partial frame is discarded, the state returns to IDLE, and RAM contents already written are left as they are.

## Timing
- Reset values: `o_ready`=0, `o_busy`=0, `o_wren`=0, `o_done`=0, all addresses 0, all data 0, `n`=0, hold=0.
- All outputs are registered. The RAM clocks on the inverted clock, so a write presented after edge T lands at the falling edge of the same cycle.
- Start-to-ready latency: `i_start` sampled at edge T gives `o_ready`=1 after T.
- Write latency: odd sample accepted at edge T gives `o_wren`=1 for the cycle after T; otherwise `o_wren`=0.
- Last sample accepted at edge T:
  - FLUSH write in the cycle after T.
  - `o_done` in the cycle after T+1.
  - IDLE after T+2.
- Minimum frame time with `i_valid` held high: 1 (start) + `FFT_SIZE` + 2 cycles.
- `o_wraddr`/`o_wrdata` hold their last values when `o_wren`=0.

## Test plan
- Reset, then idle 5 cycles → all outputs 0; `i_valid`=1 with `i_start`=0 consumes nothing.
- Start, then samples re=0..7, im=0 streamed back-to-back (`FFT_SIZE`=8):
  - 4 writes, pairs (0,1),(2,3),(4,5),(6,7); `o_wrdata_A` for sample 2 = `{37'd2, 37'd0}`.
  - `o_done` exactly 2 cycles after the 8th accept.
  - RAM[0..7] = samples in order.
- re=-1, im=-32768 → word `{37'h1FFFFFFFFF, 37'h1FFFFF8000}`, confirming sign extension.
- `i_valid` toggled 1,0,0,1,... → `o_wren` only after each odd accept, addresses still 0/1, 2/3, ...; done after the 8th sample.
- `i_start` pulsed during LOAD and `i_valid` held high during FLUSH/DONE → no restart, no extra accept, `n` unaffected.
- Reset low after 5 samples, then a new start with 8 samples 100..107 → RAM[0..7] = 100..107, `o_done` once.

Source files
------------

// File: rtl/fft_sample_loader_if.sv
// Stream-in / RAM-write bundle for fft_sample_loader.
//   slave  : loader side (consumes start/valid/samples, drives ready/busy/RAM writes/done)
//   master : upstream side (drives start/valid/samples, observes the rest)
interface fft_sample_loader_if #(
   parameter int unsigned WORD_SIZE   = 74,
   parameter int unsigned SAMPLE_SIZE = 16,
   parameter int unsigned ADDR_SIZE   = 4
);
   logic                   i_start;
   logic                   i_valid;
   logic [SAMPLE_SIZE-1:0] i_sample_re;
   logic [SAMPLE_SIZE-1:0] i_sample_im;
   logic                   o_ready;
   logic                   o_busy;
   logic                   o_wren;
   logic [ADDR_SIZE-1:0]   o_wraddr_A;
   logic [ADDR_SIZE-1:0]   o_wraddr_B;
   logic [WORD_SIZE-1:0]   o_wrdata_A;
   logic [WORD_SIZE-1:0]   o_wrdata_B;
   logic                   o_done;

   modport slave (
      input  i_start, i_valid, i_sample_re, i_sample_im,
      output o_ready, o_busy, o_wren, o_wraddr_A, o_wraddr_B, o_wrdata_A, o_wrdata_B, o_done
   );

   modport master (
      output i_start, i_valid, i_sample_re, i_sample_im,
      input  o_ready, o_busy, o_wren, o_wraddr_A, o_wraddr_B, o_wrdata_A, o_wrdata_B, o_done
   );
endinterface

// File: rtl/fft_sample_loader.sv
// FFT input stage: accepts FFT_SIZE complex samples on a valid/ready stream, sign-extends
// each part to WORD_SIZE/2 bits and writes even/odd sample pairs into the FFT RAM through
// its A/B ports. A one-cycle o_done follows the final pair write.
// Ports:
//   i_CLK  - clock, rising edge
//   i_RST  - asynchronous active-low reset
//   bus    - fft_sample_loader_if.slave (start/valid/samples in; ready/busy/RAM write/done out)
// All outputs are registered.
module fft_sample_loader #(
   parameter int unsigned WORD_SIZE   = 74,
   parameter int unsigned SAMPLE_SIZE = 16,
   parameter int unsigned FFT_SIZE    = 8,
   parameter int unsigned ADDR_SIZE   = 4,
   parameter int unsigned BASE_ADDR   = 0
) (
   input logic               i_CLK,
   input logic               i_RST,
   fft_sample_loader_if.slave bus
);

   localparam int unsigned HalfW = WORD_SIZE / 2;
   localparam int unsigned CntW  = $clog2(FFT_SIZE);

   typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       n_q, n_d;
   logic [WORD_SIZE-1:0]  hold_q, hold_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  wren_q, wren_d;
   logic                  done_q, done_d;
   logic [ADDR_SIZE-1:0]  addr_a_q, addr_a_d;
   logic [ADDR_SIZE-1:0]  addr_b_q, addr_b_d;
   logic [WORD_SIZE-1:0]  data_a_q, data_a_d;
   logic [WORD_SIZE-1:0]  data_b_q, data_b_d;

   logic                  accept;
   logic [HalfW-1:0]      re_ext, im_ext;
   logic [WORD_SIZE-1:0]  word;
   logic [ADDR_SIZE-1:0]  addr_odd;

   // Size cast of a signed operand sign-extends.
   assign re_ext   = HalfW'(signed'(bus.i_sample_re));
   assign im_ext   = HalfW'(signed'(bus.i_sample_im));
   assign word     = {re_ext, im_ext};
   assign accept   = (state_q == StLoad) && bus.i_valid;
   assign addr_odd = ADDR_SIZE'(BASE_ADDR) + ADDR_SIZE'(n_q);

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      hold_d   = hold_q;
      wren_d   = 1'b0;
      done_d   = 1'b0;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      data_a_d = data_a_q;
      data_b_d = data_b_q;

      unique case (state_q)
         StIdle: begin
            if (bus.i_start) begin
               state_d = StLoad;
               n_d     = '0;
            end
         end
         StLoad: begin
            if (accept) begin
               n_d = n_q + 1'b1;
               if (n_q[0]) begin
                  // Odd sample completes a pair: write hold + current word next cycle.
                  wren_d   = 1'b1;
                  addr_a_d = addr_odd - ADDR_SIZE'(1);
                  addr_b_d = addr_odd;
                  data_a_d = hold_q;
                  data_b_d = word;
               end else begin
                  hold_d = word;
               end
               if (n_q == CntW'(FFT_SIZE - 1)) state_d = StFlush;
            end
         end
         // The final pair write is already on the bus during this state.
         StFlush: begin
            state_d = StDone;
            done_d  = 1'b1;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      ready_d = (state_d == StLoad);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         state_q  <= StIdle;
         n_q      <= '0;
         hold_q   <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         wren_q   <= 1'b0;
         done_q   <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         hold_q   <= hold_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         wren_q   <= wren_d;
         done_q   <= done_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
      end
   end

   assign bus.o_ready    = ready_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_wren     = wren_q;
   assign bus.o_done     = done_q;
   assign bus.o_wraddr_A = addr_a_q;
   assign bus.o_wraddr_B = addr_b_q;
   assign bus.o_wrdata_A = data_a_q;
   assign bus.o_wrdata_B = data_b_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader with a write scoreboard and a RAM model.
module tb_fft_sample_loader;

   localparam int unsigned WS = 74;
   localparam int unsigned SS = 16;
   localparam int unsigned FS = 8;
   localparam int unsigned AS = 4;
   localparam int unsigned BA = 0;

   typedef struct packed {
      logic [AS-1:0] aa;
      logic [AS-1:0] ab;
      logic [WS-1:0] da;
      logic [WS-1:0] db;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   int   m_n = 0;
   logic [WS-1:0] m_hold = '0;
   logic [WS-1:0] ram [16];
   wr_t  exp_q [$];

   fft_sample_loader_if #(.WORD_SIZE(WS), .SAMPLE_SIZE(SS), .ADDR_SIZE(AS)) bus ();

   fft_sample_loader #(
      .WORD_SIZE(WS), .SAMPLE_SIZE(SS), .FFT_SIZE(FS), .ADDR_SIZE(AS), .BASE_ADDR(BA)
   ) dut (
      .i_CLK(clk),
      .i_RST(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Independent word formation: explicit 21-bit sign replication for 16->37.
   function automatic logic [WS-1:0] mk_word(input logic [15:0] re, input logic [15:0] im);
      return {{21{re[15]}}, re, {21{im[15]}}, im};
   endfunction

   // Scoreboard monitor: outputs sampled on the falling edge, where the RAM also writes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.o_done) done_cnt++;
         if (bus.o_wren) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write got A=%0d B=%0d required none",
                        bus.o_wraddr_A, bus.o_wraddr_B);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if ({bus.o_wraddr_A, bus.o_wraddr_B, bus.o_wrdata_A, bus.o_wrdata_B} !== e) begin
                  bad++;
                  $display("FAIL write_pair got A=%0d B=%0d dA=%h dB=%h required A=%0d B=%0d dA=%h dB=%h",
                           bus.o_wraddr_A, bus.o_wraddr_B, bus.o_wrdata_A, bus.o_wrdata_B,
                           e.aa, e.ab, e.da, e.db);
               end
            end
            ram[bus.o_wraddr_A] = bus.o_wrdata_A;
            ram[bus.o_wraddr_B] = bus.o_wrdata_B;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic with_valid);
      bus.i_start = 1'b1;
      bus.i_valid = with_valid;
      bus.i_sample_re = 16'd55;
      bus.i_sample_im = 16'd66;
      tick();
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      m_n = 0;
      total++;
      if ({bus.o_ready, bus.o_busy} !== 2'b11) begin
         bad++;
         $display("FAIL start_ready got %b required 11", {bus.o_ready, bus.o_busy});
      end
   endtask

   // Present one sample and wait (bounded) for it to be accepted.
   task automatic send(input logic [15:0] re, input logic [15:0] im, input logic pulse_start);
      int w;
      logic [WS-1:0] word;
      word = mk_word(re, im);
      bus.i_valid = 1'b1;
      bus.i_sample_re = re;
      bus.i_sample_im = im;
      bus.i_start = pulse_start;
      w = 0;
      while (!bus.o_ready && w < 50) begin
         tick();
         w++;
      end
      if (!bus.o_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout got ready=0 required ready=1");
         bus.i_valid = 1'b0;
         bus.i_start = 1'b0;
         return;
      end
      if (m_n % 2 == 1)
         exp_q.push_back('{aa: AS'(BA + m_n - 1), ab: AS'(BA + m_n), da: m_hold, db: word});
      else
         m_hold = word;
      tick();
      bus.i_valid = 1'b0;
      bus.i_start = 1'b0;
      total++;
      if (bus.o_wren !== 1'(m_n % 2)) begin
         bad++;
         $display("FAIL wren_after_accept n=%0d got %b required %b", m_n, bus.o_wren, 1'(m_n % 2));
      end
      m_n = (m_n + 1) % FS;
   endtask

   // Last sample just accepted: FLUSH write, then DONE, then IDLE.
   task automatic check_tail(input string tag, input int done_before);
      total++;
      if ({bus.o_wren, bus.o_done, bus.o_ready, bus.o_busy} !== 4'b1001) begin
         bad++;
         $display("FAIL %s_flush got %b required 1001", tag,
                  {bus.o_wren, bus.o_done, bus.o_ready, bus.o_busy});
      end
      tick();
      total++;
      if ({bus.o_wren, bus.o_done, bus.o_ready, bus.o_busy} !== 4'b0101) begin
         bad++;
         $display("FAIL %s_done got %b required 0101", tag,
                  {bus.o_wren, bus.o_done, bus.o_ready, bus.o_busy});
      end
      tick();
      total++;
      if ({bus.o_done, bus.o_busy, bus.o_ready} !== 3'b000) begin
         bad++;
         $display("FAIL %s_idle got %b required 000", tag, {bus.o_done, bus.o_busy, bus.o_ready});
      end
      total++;
      if (done_cnt - done_before !== 1) begin
         bad++;
         $display("FAIL %s_done_count got %0d required 1", tag, done_cnt - done_before);
      end
   endtask

   task automatic check_ram(input string tag, input logic [15:0] re0);
      for (int i = 0; i < FS; i++) begin
         total++;
         if (ram[BA + i] !== mk_word(re0 + 16'(i), 16'd0)) begin
            bad++;
            $display("FAIL %s_ram[%0d] got %h required %h", tag, i, ram[BA + i],
                     mk_word(re0 + 16'(i), 16'd0));
         end
      end
   endtask

   task automatic test_reset();
      logic [WS-1:0] zw;
      zw = '0;
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_sample_re = '0;
      bus.i_sample_im = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if ({bus.o_ready, bus.o_busy, bus.o_wren, bus.o_done, bus.o_wraddr_A, bus.o_wraddr_B,
              bus.o_wrdata_A, bus.o_wrdata_B} !== {4'b0, 8'd0, zw, zw}) begin
            bad++;
            $display("FAIL reset_idle cycle=%0d got r=%b b=%b w=%b d=%b required all 0", c,
                     bus.o_ready, bus.o_busy, bus.o_wren, bus.o_done);
         end
      end
   endtask

   task automatic test_idle_valid();
      bus.i_valid = 1'b1;
      bus.i_sample_re = 16'd9;
      repeat (4) tick();
      bus.i_valid = 1'b0;
      total++;
      if ({bus.o_ready, bus.o_busy} !== 2'b00) begin
         bad++;
         $display("FAIL idle_valid got %b required 00", {bus.o_ready, bus.o_busy});
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      logic [WS-1:0] w2;
      w2 = {37'd2, 37'd0};
      d0 = done_cnt;
      do_start(1'b0);
      for (int i = 0; i < FS; i++) begin
         send(16'(i), 16'd0, 1'b0);
         if (i == 3) begin
            total++;
            if (bus.o_wrdata_A !== w2) begin
               bad++;
               $display("FAIL ramp_sample2 got %h required %h", bus.o_wrdata_A, w2);
            end
         end
      end
      check_tail("ramp", d0);
      check_ram("ramp", 16'd0);
   endtask

   task automatic test_sign_ext();
      int d0;
      logic [WS-1:0] wneg;
      wneg = {37'h1FFFFFFFFF, 37'h1FFFFF8000};
      d0 = done_cnt;
      do_start(1'b1);  // valid alongside start must not be consumed
      send(16'hFFFF, 16'h8000, 1'b0);
      send(16'd5, 16'hFFFD, 1'b0);
      total++;
      if (bus.o_wrdata_A !== wneg) begin
         bad++;
         $display("FAIL sign_ext got %h required %h", bus.o_wrdata_A, wneg);
      end
      for (int i = 2; i < FS; i++) send(16'(i * 7), 16'(-i), 1'b0);
      check_tail("sign", d0);
   endtask

   task automatic test_gaps();
      int d0;
      d0 = done_cnt;
      do_start(1'b0);
      for (int i = 0; i < FS; i++) begin
         send(16'(i + 20), 16'd0, 1'b0);
         if (i != FS - 1) begin
            repeat (2) begin
               tick();
               total++;
               if (bus.o_wren !== 1'b0) begin
                  bad++;
                  $display("FAIL gap_wren got 1 required 0");
               end
            end
         end
      end
      check_tail("gaps", d0);
      check_ram("gaps", 16'd20);
   endtask

   task automatic test_start_in_load();
      int d0;
      d0 = done_cnt;
      do_start(1'b0);
      for (int i = 0; i < FS; i++) send(16'(i + 40), 16'd0, (i == 3) || (i == 6));
      // Hold valid through FLUSH/DONE and one IDLE cycle: nothing may be consumed.
      bus.i_valid = 1'b1;
      bus.i_sample_re = 16'd999;
      check_tail("noretrig", d0);
      tick();
      bus.i_valid = 1'b0;
      total++;
      if ({bus.o_busy, bus.o_wren} !== 2'b00) begin
         bad++;
         $display("FAIL noretrig_after got %b required 00", {bus.o_busy, bus.o_wren});
      end
      check_ram("noretrig", 16'd40);
   endtask

   task automatic test_reset_midframe();
      int d0;
      do_start(1'b0);
      for (int i = 0; i < 5; i++) send(16'(i + 70), 16'd0, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.o_ready, bus.o_busy, bus.o_wren, bus.o_done} !== 4'b0000) begin
         bad++;
         $display("FAIL midreset got %b required 0000",
                  {bus.o_ready, bus.o_busy, bus.o_wren, bus.o_done});
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL midreset_pending got %0d required 0", exp_q.size());
      end
      exp_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      d0 = done_cnt;
      do_start(1'b0);
      for (int i = 0; i < FS; i++) send(16'(i + 100), 16'd0, 1'b0);
      check_tail("after_reset", d0);
      check_ram("after_reset", 16'd100);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = '0;
      test_reset();
      test_idle_valid();
      test_back_to_back();
      test_sign_ext();
      test_gaps();
      test_start_in_load();
      test_reset_midframe();
      repeat (3) tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_writes got %0d required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
